// File: rtl/gauss_line_sched.sv
// Read scheduler/sequencer for the 3x3 Gaussian line-buffer datapath: prime, stream, flush, done.
// Optional GAUSS_SCHED_STALL_CNT_EN adds a saturating RUN-stall counter output stall_cnt.
module gauss_line_sched #(
    parameter int LINE_W      = 300,
    parameter int FRAME_H     = 300,
    parameter int CW          = 9,
    parameter int PRIME_LINES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          fifo_empty,
    input  logic          out_ready,
    output logic          rdreq,
    output logic          lb_shift,
    output logic          pad,
    output logic          win_valid,
    output logic [CW-1:0] col,
    output logic [CW-1:0] row,
    output logic          frame_done,
    output logic          busy
`ifdef GAUSS_SCHED_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    // state  | meaning
    // IDLE   | waiting for start
    // PRIME  | loading the first PRIME_LINES lines, no windows yet
    // RUN    | one read and one window per step, gated by out_ready
    // FLUSH  | padded steps drain the last PRIME_LINES lines
    // DONE   | frame finished, frame_done follows
    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [CW-1:0] C_MAX   = CW'(LINE_W - 1);
    localparam logic [CW-1:0] R_LAST  = CW'(FRAME_H - 1);
    localparam logic [CW-1:0] R_PRIME = CW'(PRIME_LINES - 1);
    localparam logic [CW-1:0] R_OFS   = CW'(FRAME_H);

    state_t        state, state_nxt;
    logic [CW-1:0] c, r, c_nxt, r_nxt;
    logic          step;
    logic          c_last;

    always_comb begin
        state_nxt = state;
        c_nxt     = c;
        r_nxt     = r;
        step      = 1'b0;
        rdreq     = 1'b0;
        c_last    = (c == C_MAX);
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_PRIME;
                    c_nxt     = '0;
                    r_nxt     = '0;
                end
            end
            S_PRIME: begin
                step  = !fifo_empty;
                rdreq = step;
            end
            S_RUN: begin
                step  = !fifo_empty && out_ready;
                rdreq = step;
            end
            S_FLUSH: step = out_ready;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        if (step) begin
            if (c_last) begin
                c_nxt = '0;
                r_nxt = r + CW'(1);
            end else begin
                c_nxt = c + CW'(1);
            end
            // r keeps counting across PRIME->RUN; FLUSH restarts it at 0
            if (state == S_PRIME && c_last && r == R_PRIME) state_nxt = S_RUN;
            if (state == S_RUN && c_last && r == R_LAST) begin
                state_nxt = S_FLUSH;
                r_nxt     = '0;
            end
            if (state == S_FLUSH && c_last && r == R_PRIME) state_nxt = S_DONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            c          <= '0;
            r          <= '0;
            lb_shift   <= 1'b0;
            pad        <= 1'b0;
            win_valid  <= 1'b0;
            col        <= '0;
            row        <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            c          <= c_nxt;
            r          <= r_nxt;
            lb_shift   <= step;
            pad        <= step && (state == S_FLUSH);
            win_valid  <= step && (state == S_RUN || state == S_FLUSH);
            frame_done <= (state == S_DONE);
            if (step) begin
                col <= c;
                row <= (state == S_FLUSH) ? (r + R_OFS) : r;
            end
        end
    end

    // frame_done lands in IDLE, so keep busy up until the pulse has been seen
    assign busy = (state != S_IDLE) || frame_done;

`ifdef GAUSS_SCHED_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            stall_cnt <= '0;
        end else if (state == S_RUN && !rdreq && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gauss_line_sched.sv
// Bench for gauss_line_sched: count-based frame model checked every cycle plus directed literal checks.
module tb_gauss_line_sched;
    localparam int LW = 4;
    localparam int FH = 3;
    localparam int PL = 2;
    localparam int CW = 4;
    localparam int N  = LW * FH;
    localparam int PS = PL * LW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          fifo_empty = 1'b0;
    logic          out_ready = 1'b1;
    logic          rdreq, lb_shift, pad, win_valid, frame_done, busy;
    logic [CW-1:0] col, row;
`ifdef GAUSS_SCHED_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    gauss_line_sched #(.LINE_W(LW), .FRAME_H(FH), .CW(CW), .PRIME_LINES(PL)) dut (
        .clk(clk), .rst(rst), .start(start), .fifo_empty(fifo_empty), .out_ready(out_ready),
        .rdreq(rdreq), .lb_shift(lb_shift), .pad(pad), .win_valid(win_valid),
        .col(col), .row(row), .frame_done(frame_done), .busy(busy)
`ifdef GAUSS_SCHED_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int test_id = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // model: a frame is N reads followed by PS flush steps; step k maps to col=k%LW, row=k/LW
    bit          act;
    int          nrd, nfl;
    bit          e_lb, e_pad, e_wv, e_fd;
    int          e_col, e_row;
    logic [15:0] e_st;
    int          rd_t, lb_t, wv_t, fd_cnt, cyc, frd, fwv, lastwv;
    int          first_col, first_row;
    int          q_row2[$];

    always @(negedge clk) begin
        bit e_rd, fstep, step, n_fd, was_act;
        int k;
        cyc++;
        if (!rst) begin
            act = 0; nrd = 0; nfl = 0;
            e_lb = 0; e_pad = 0; e_wv = 0; e_fd = 0; e_col = 0; e_row = 0; e_st = '0;
        end
        e_rd  = act && nrd < N && !fifo_empty && (nrd < PS || out_ready);
        fstep = act && nrd == N && nfl < PS && out_ready;
        chk("rdreq", rdreq, e_rd);
        chk("lb_shift", lb_shift, e_lb);
        chk("pad", pad, e_pad);
        chk("win_valid", win_valid, e_wv);
        chk("col", col, e_col);
        chk("row", row, e_row);
        chk("frame_done", frame_done, e_fd);
        chk("busy", busy, act || e_fd);
`ifdef GAUSS_SCHED_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, e_st);
`endif
        if (rdreq) begin
            if (rd_t == 0) frd = cyc;
            rd_t++;
        end
        if (lb_shift) begin
            if (lb_t == 0) begin first_col = col; first_row = row; end
            lb_t++;
            if (test_id == 3 && row == 2) q_row2.push_back(int'(col));
        end
        if (win_valid) begin
            if (wv_t == 0) fwv = cyc;
            wv_t++;
            lastwv = cyc;
        end
        if (frame_done) begin
            fd_cnt++;
            chk("total_rdreq", rd_t, 12);
            chk("total_lb_shift", lb_t, 20);
            chk("total_win_valid", wv_t, 12);
            chk("fd_after_last_wv", cyc - lastwv, 1);
            if (test_id == 1) chk("first_wv_delay", fwv - frd, 9);
`ifdef GAUSS_SCHED_STALL_CNT_EN
            if (test_id == 6) chk("stall_cnt_at_done", stall_cnt, 7);
`endif
        end
        if (rst) begin
            step = e_rd || fstep;
            k = nrd + nfl;
            n_fd = act && nrd == N && nfl == PS;
            was_act = act;
            e_lb = step;
            e_pad = fstep;
            e_wv = step && k >= PS;
            if (step) begin e_col = k % LW; e_row = k / LW; end
            if (act && nrd >= PS && nrd < N && !e_rd && e_st != 16'hFFFF) e_st = e_st + 16'd1;
            if (e_rd) nrd++;
            if (fstep) nfl++;
            e_fd = n_fd;
            if (n_fd) act = 0;
            if (!was_act && start) begin
                act = 1; nrd = 0; nfl = 0; e_st = '0;
                rd_t = 0; lb_t = 0; wv_t = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_fd(input int maxc);
        int f0 = fd_cnt;
        int n = 0;
        while (fd_cnt == f0 && n < maxc) begin tick(); n++; end
        if (fd_cnt == f0) chk("frame_done_timeout", 0, 1);
        repeat (2) tick();
    endtask

    initial begin
        int f0, n;
        repeat (2) tick();
        chk("rst_rdreq", rdreq, 0);
        chk("rst_lb_shift", lb_shift, 0);
        chk("rst_pad", pad, 0);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_col", col, 0);
        chk("rst_row", row, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        tick();

        test_id = 1;
        start_pulse();
        wait_fd(100);

        test_id = 2;
        out_ready = 1'b0;
        start_pulse();
        repeat (20) tick();
        chk("prime_reads_no_ready", rd_t, 8);
        chk("prime_held_busy", busy, 1);
        out_ready = 1'b1;
        wait_fd(100);

        test_id = 3;
        q_row2.delete();
        start_pulse();
        f0 = fd_cnt;
        n = 0;
        while (fd_cnt == f0 && n < 200) begin
            fifo_empty = ~fifo_empty;
            tick();
            n++;
        end
        fifo_empty = 1'b0;
        if (fd_cnt == f0) chk("frame_done_timeout", 0, 1);
        repeat (2) tick();
        chk("row2_count", q_row2.size(), 4);
        for (int i = 0; i < q_row2.size() && i < 4; i++) chk("row2_col", q_row2[i], i);

        test_id = 4;
        start_pulse();
        n = 0;
        while (rd_t < 5 && n < 50) begin tick(); n++; end
        chk("reads_before_reset", rd_t, 5);
        f0 = fd_cnt;
        rst = 1'b0;
        tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_lb_shift", lb_shift, 0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (20) tick();
        chk("no_fd_after_abort", fd_cnt - f0, 0);
        start_pulse();
        wait_fd(100);
        chk("restart_first_col", first_col, 0);
        chk("restart_first_row", first_row, 0);

        test_id = 5;
        f0 = fd_cnt;
        start_pulse();
        repeat (8) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();
        chk("one_frame_done", fd_cnt - f0, 1);
        chk("idle_after_ignored_start", busy, 0);

        test_id = 6;
        start_pulse();
        repeat (8) tick();
        out_ready = 1'b0;
        repeat (7) tick();
        out_ready = 1'b1;
        wait_fd(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
